// File: rtl/nrs_cinit_seq_if.sv
// Command/seed bundle for the NRS/CRS scrambling-seed sequencer.
// The master side issues commands and consumes seeds; the slave side is the sequencer.
interface nrs_cinit_seq_if #(
  parameter int WIDTH_B = 9
);
  logic               start;
  logic [WIDTH_B-1:0] N_cell_ID;
  logic               ncp;
  logic [4:0]         start_slot;
  logic [4:0]         num_slots;
  logic [30:0]        cinit;
  logic               valid;
  logic               ready;
  logic               last;
  logic               busy;
  logic               done;

  modport master (
    output start, N_cell_ID, ncp, start_slot, num_slots, ready,
    input  cinit, valid, last, busy, done
  );

  modport slave (
    input  start, N_cell_ID, ncp, start_slot, num_slots, ready,
    output cinit, valid, last, busy, done
  );
endinterface

// File: rtl/nrs_cinit_seq.sv
// Walks (slot, symbol) pairs and emits the Gold-sequence seed
// c_init = 2^10*(7*(ns+1)+l+1)*(2*N_cell_ID+1) + 2*N_cell_ID + N_CP for each pair.
module nrs_cinit_seq #(
  parameter int                WIDTH_B = 9,
  parameter int                NSYM    = 2,
  parameter logic [3*NSYM-1:0] L_LIST  = {3'd6, 3'd5}
) (
  input  logic              clk,
  input  logic              rst,
  nrs_cinit_seq_if.slave    bus
);

  localparam int B_W   = WIDTH_B + 1;
  localparam int ACC_W = 8 + B_W;
  localparam int SUM_W = (ACC_W + 10 > 31) ? ACC_W + 10 : 31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_OUT
  } state_e;

  state_e             state_q;
  logic [WIDTH_B-1:0] n_cell_q;
  logic               ncp_q;
  logic [4:0]         slot_q;
  logic [4:0]         rem_q;
  logic [1:0]         si_q;
  logic [7:0]         a_q;
  logic [B_W-1:0]     b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [2:0]         bit_q;
  logic [30:0]        cinit_q;
  logic               valid_q;
  logic               last_q;
  logic               busy_q;
  logic               done_q;

  logic [2:0]         l_sel;
  logic [7:0]         a_d;
  logic [ACC_W-1:0]   acc_d;
  logic [SUM_W-1:0]   sum;
  logic [30:0]        cinit_d;
  logic               last_pair;
  logic               start_ok;

  // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
  always_comb begin
    l_sel = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (si_q == 2'(i)) l_sel = L_LIST[3*i +: 3];
    end
    a_d       = ({3'b000, slot_q} + 8'd1) * 8'd7 + {5'b00000, l_sel} + 8'd1;
    acc_d     = acc_q + (a_q[bit_q] ? (ACC_W'(b_q) << bit_q) : '0);
    // Mod-2^31 truncation of the seed is implicit in taking the low 31 bits.
    sum       = (SUM_W'(acc_d) << 10) + SUM_W'(b_q) - SUM_W'(1) + SUM_W'(ncp_q);
    cinit_d   = sum[30:0];
    last_pair = (rem_q == 5'd1) && (si_q == 2'(NSYM - 1));
    start_ok  = bus.start && (bus.num_slots != 5'd0) && (bus.num_slots <= 5'd20)
                && (bus.start_slot <= 5'd19);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_cell_q <= '0;
      ncp_q    <= 1'b0;
      slot_q   <= '0;
      rem_q    <= '0;
      si_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      cinit_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            n_cell_q <= bus.N_cell_ID;
            ncp_q    <= bus.ncp;
            slot_q   <= bus.start_slot;
            rem_q    <= bus.num_slots;
            si_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end

        S_LOAD: begin
          a_q     <= a_d;
          b_q     <= {n_cell_q, 1'b1};
          acc_q   <= '0;
          bit_q   <= '0;
          state_q <= S_MUL;
        end

        S_MUL: begin
          acc_q <= acc_d;
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            cinit_q <= cinit_d;
            valid_q <= 1'b1;
            last_q  <= last_pair;
            state_q <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cinit_q <= '0;
            if (si_q == 2'(NSYM - 1)) begin
              si_q   <= '0;
              slot_q <= (slot_q == 5'd19) ? 5'd0 : slot_q + 5'd1;
              rem_q  <= rem_q - 5'd1;
            end else begin
              si_q <= si_q + 2'd1;
            end
            if (last_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cinit = cinit_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
